// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // (a + b) mod n, valid for a < n and b <= n.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_cand = ID_W'(wrap_add(32'(i_ptr), i, N_REQ));
      if (!o_any && i_req_valid[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sequencing byte requesters onto one UART transmitter.
// Optional START timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_busy,
  output logic                      tx_sent,
  output logic [BYTE_W-1:0]         tx_din,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      active,
  output logic                      err
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  // Reject illegal configurations at elaboration.
  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be 2..16 and TIMEOUT >= 1");
  end

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [ID_W-1:0]   r_ptr;
  logic [BYTE_W-1:0] r_tx_din;
  logic [ID_W-1:0]   r_grant_id;
  logic              w_accept;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic [BYTE_W-1:0] w_sel_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_expired;
  logic             w_timeout;

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req_valid (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  assign w_sel_byte = req_data[int'(w_idx)*BYTE_W +: BYTE_W];

  // Accept is gated by rst so req_ready reads 0 while reset is held.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_accept  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_any && rst) begin
          req_ready = w_grant;
          w_accept  = 1'b1;
          w_next    = START;
        end
      end
      START: begin
        if (tx_busy) begin
          w_next = WAIT;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (w_expired) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (!tx_busy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Latch the granted byte and advance the round-robin pointer past the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_tx_din   <= '0;
      r_grant_id <= '0;
    end else if (w_accept) begin
      r_ptr      <= ID_W'(wrap_add(32'(w_idx), 1, N_REQ));
      r_tx_din   <= w_sel_byte;
      r_grant_id <= w_idx;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_accept)                r_cnt <= '0;
      else if (r_state == START)   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign tx_sent  = (r_state == START);
  assign active   = (r_state != IDLE);
  assign tx_din   = r_tx_din;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a simple transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_busy;
  logic           tx_sent;
  logic [7:0]     tx_din;
  logic [1:0]     grant_id;
  logic           active;
  logic           err;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic model_en = 1'b1;
  int   tx_cnt;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_busy   (tx_busy),
    .tx_sent   (tx_sent),
    .tx_din    (tx_din),
    .grant_id  (grant_id),
    .active    (active),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises 2 cycles after Sent is seen, stays high 10 cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end else if (!model_en) begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end else if (!tx_busy) begin
      if (tx_sent) begin
        if (tx_cnt == 1) begin
          tx_busy <= 1'b1;
          tx_cnt  <= 0;
        end else begin
          tx_cnt <= tx_cnt + 1;
        end
      end else begin
        tx_cnt <= 0;
      end
    end else begin
      if (tx_cnt == 9) begin
        tx_busy <= 1'b0;
        tx_cnt  <= 0;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int idx, input logic [7:0] val);
    req_data[idx*8 +: 8] = val;
  endtask

  // Follow one transaction from accept to the first IDLE cycle after busy falls.
  task automatic expect_txn(input bit drop, output int waited);
    exp_t e;
    int   n;
    #1;
    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    e = exp_q.pop_front();
    waited = 0;
    while (req_ready == '0 && waited < 40) begin
      tick();
      waited++;
    end
    chk("req_ready", 32'(req_ready), 32'(1) << e.id);
    tick();
    if (drop) req_valid[e.id] = 1'b0;
    chk("ready_pulse", 32'(req_ready), 32'd0);
    chk("tx_din", 32'(tx_din), 32'(e.data));
    chk("grant_id", 32'(grant_id), 32'(e.id));
    chk("sent_rise", 32'(tx_sent), 32'd1);
    n = 0;
    while (tx_sent === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("sent_len", 32'(n), 32'd3);
    chk("busy_at_sent_fall", 32'(tx_busy), 32'd1);
    n = 0;
    while (tx_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("wait_no_ready", 32'(req_ready), 32'd0);
    chk("wait_active", 32'(active), 32'd1);
    tick();
    chk("idle_active", 32'(active), 32'd0);
  endtask

  initial begin
    int w;
    int k;
    int bad;
    exp_t e;

    // Reset values
    tick();
    tick();
    chk("rst_sent", 32'(tx_sent), 32'd0);
    chk("rst_din", 32'(tx_din), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();

    // Single requester 2, ptr becomes 3
    set_byte(2, 8'hA5);
    req_valid = 4'b0100;
    e.id = 2'd2; e.data = 8'hA5; exp_q.push_back(e);
    expect_txn(1'b1, w);

    // ptr=3 with requesters 0 and 3: 3 first, then wrap to 0
    set_byte(0, 8'h10);
    set_byte(3, 8'h33);
    req_valid = 4'b1001;
    e.id = 2'd3; e.data = 8'h33; exp_q.push_back(e);
    e.id = 2'd0; e.data = 8'h10; exp_q.push_back(e);
    expect_txn(1'b1, w);
    expect_txn(1'b1, w);

    // Reset during WAIT: ptr=1 so requester 2 wins
    set_byte(2, 8'h5C);
    req_valid = 4'b0100;
    #1;
    k = 0;
    while (req_ready == '0 && k < 40) begin
      tick();
      k++;
    end
    chk("pre_rst_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    k = 0;
    while (!(tx_busy === 1'b1 && tx_sent === 1'b0) && k < 40) begin
      tick();
      k++;
    end
    chk("pre_rst_active", 32'(active), 32'd1);
    req_valid = 4'hF;
    rst = 1'b0;
    #1;
    chk("mid_rst_sent", 32'(tx_sent), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_din", 32'(tx_din), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    tick();
    tick();
    chk("rst_hold_ready", 32'(req_ready), 32'd0);

    // All valid after release: 0,1,2,3,0 with a single IDLE cycle between grants
    for (int i = 0; i < 4; i++) set_byte(i, 8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      e.id = 2'(i % 4); e.data = 8'hC0 + 8'(i % 4); exp_q.push_back(e);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_txn(1'b0, w);
      chk("gap_idle", 32'(w), 32'd0);
    end
    req_valid = '0;

    // Busy never comes: ptr=1 so requester 1 is served
    model_en = 1'b0;
    tick();
    set_byte(1, 8'h77);
    req_valid = 4'b0010;
    #1;
    k = 0;
    while (req_ready == '0 && k < 40) begin
      tick();
      k++;
    end
    chk("stall_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("stall_din", 32'(tx_din), 32'h77);
`ifdef UART_ARB_TIMEOUT_EN
    k = 0;
    while (err !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("to_len", 32'(k), 32'd15);
    chk("to_sent", 32'(tx_sent), 32'd0);
    chk("to_active", 32'(active), 32'd0);
    tick();
    chk("to_err_pulse", 32'(err), 32'd0);
    model_en = 1'b1;
    set_byte(2, 8'h88);
    req_valid = 4'b0110;
    e.id = 2'd2; e.data = 8'h88; exp_q.push_back(e);
    expect_txn(1'b1, w);
    req_valid = '0;
`else
    bad = 0;
    repeat (1000) begin
      tick();
      if (tx_sent !== 1'b1 || err !== 1'b0) bad++;
    end
    chk("hold_bad_cycles", 32'(bad), 32'd0);
    chk("hold_active", 32'(active), 32'd1);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer sharing one UART transmitter between N_REQ byte requesters. Accepts one byte from the granted requester and drives the transmitter's `Sent`/`Din` inputs. It holds `Sent` until the transmitter reports `Busy`, then waits for `Busy` to fall before the next grant. It sits between the UART receive path, FIFO and other byte sources on one side and the UART transmitter's `Sent`/`Busy`/`Din` pins on the other.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Legal range 2..16.
- `TIMEOUT`, default 1023: cycles allowed in START waiting for `tx_busy`. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, N_REQ: requester i has a byte pending.
- `req_data`, input, 8*N_REQ: byte of requester i is at `[8i+7:8i]`.
- `req_ready`, output, N_REQ: one-hot, one-cycle accept pulse.
- `tx_busy`, input, 1: transmitter `Busy`.
- `tx_sent`, output, 1: to transmitter `Sent`.
- `tx_din`, output, 8: to transmitter `Din`. Registered.
- `grant_id`, output, clog2(N_REQ): index of the last accepted requester.
- `active`, output, 1: high in START or WAIT.
- `err`, output, 1: one-cycle timeout pulse.

## Operation
- FSM states: IDLE, START, WAIT.
- IDLE:
  - If any `req_valid` is high, pick the first set bit searching upward from `ptr`, with wrap-around.
  - Pulse `req_ready[g]`, latch `req_data[g]` into `tx_din`, set `grant_id`=g and `ptr`=(g+1) mod N_REQ, then go to START.
  - If no `req_valid` is set, stay in IDLE. `req_ready` is 0.
- START: `tx_sent`=1. When `tx_busy`=1, go to WAIT.
- WAIT: `tx_sent`=0. When `tx_busy`=0, go to IDLE.
- `req_ready` is never asserted outside IDLE. `req_valid` is ignored in START and WAIT.
- Requesters must hold `req_valid` and their data stable until `req_ready`. The arbiter does not check this.
- `tx_din` is stable from START entry until the next accept.
- Fairness: a requester that stays valid is served within N_REQ grants.

## Timing
- Reset values: `tx_sent`=0, `tx_din`=0, `req_ready`=0, `grant_id`=0, `active`=0, `err`=0, `ptr`=0, state=IDLE.
- Accept latency:
  - `req_ready` is asserted combinationally in the same IDLE cycle in which `req_valid` is seen.
  - `tx_sent` rises the following cycle.
- `tx_sent` falls in the cycle after `tx_busy` is sampled high.
- Minimum gap: one IDLE cycle between `tx_busy` falling and the next `req_ready`.
- `tx_busy` already high on START entry: leave START after one cycle.
- Simultaneous requests resolve by `ptr` alone. No requester has fixed priority.
- Single requester asserting continuously: back-to-back grants to it, `ptr` wraps correctly.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge. Any in-flight byte is dropped. The transmitter shares `rst`.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT+1) runs in START.
  - It clears on START entry.
  - If it reaches TIMEOUT without `tx_busy`, `err` pulses for one cycle, `tx_sent` drops and the FSM returns to IDLE.
  - The byte is discarded and `ptr` is not rolled back.
- `UART_ARB_TIMEOUT_EN` undefined: no counter. START waits indefinitely and `err` is tied to 0.

## Structure
- Package `uart_arb_pkg`: state enum {IDLE, START, WAIT} and the byte-width constant 8.
- Sub-module `uart_rr_pick`:
  - Purely combinational.
  - Inputs: `req_valid` and `ptr`.
  - Outputs: a one-hot grant, its index and an any-valid flag.
- The top level holds the FSM, the `ptr`/`tx_din`/`grant_id` registers and the optional timeout counter.

## Test plan
- Single requester: N_REQ=4, `req_valid`=4'b0100, data 8'hA5, with a transmitter model raising busy 2 cycles after sent for 10 cycles.
  - Expect `req_ready`=4'b0100 for one cycle, then `tx_din`=8'hA5 and `tx_sent` high until busy is sampled high.
  - Expect `grant_id`=2 and `ptr`=3.
- All requesters valid continuously, each with a distinct byte.
  - Expect grant order 0,1,2,3,0 and bytes transmitted in that order.
  - Expect exactly one IDLE cycle between busy falling and the next `req_ready`.
- `ptr`=3 with requesters 0 and 3 valid: expect requester 3 first, then requester 0 (wrap-around).
- Reset asserted during WAIT: expect `tx_sent`/`active`/`req_ready`=0 and `ptr`=0 immediately. After release, requester 0 wins a full-valid contest.
- Timeout (`UART_ARB_TIMEOUT_EN`, TIMEOUT=15), `tx_busy` tied 0:
  - Expect `err` to pulse 15 cycles after START entry, then `tx_sent`=0 and return to IDLE.
  - Expect the next grant to go to the following requester.
- Macro undefined with `tx_busy` tied 0: expect `tx_sent` to stay high for 1000 cycles and `err` to stay 0.
